// File: rtl/hull_sync_fifo.sv
// Synchronous FIFO with optional first-word-fall-through read,
// programmable almost-full/almost-empty levels and sticky error flags.
module hull_sync_fifo #(
    parameter int WIDTH     = 32,
    parameter int LOG_DEPTH = 4,
    parameter int FWFT      = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 wrreq,
    input  logic [WIDTH-1:0]     data,
    output logic                 full,
    input  logic                 rdreq,
    output logic [WIDTH-1:0]     q,
    output logic                 empty,
    output logic                 rd_valid,
    output logic [LOG_DEPTH:0]   count,
    input  logic [LOG_DEPTH:0]   af_thresh,
    input  logic [LOG_DEPTH:0]   ae_thresh,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 clear_err
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH:0] FULL_COUNT = (LOG_DEPTH + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [WIDTH-1:0]     head;
    logic                 wr_en;
    logic                 rd_en;
    logic                 wr_err;
    logic                 rd_err;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Status comes from the registered count only, so a read from a
    // full FIFO never opens a slot for a write in the same cycle.
    assign wr_en  = wrreq && !full && !flush;
    assign rd_en  = rdreq && !empty && !flush;
    assign wr_err = wrreq && full && !flush;
    assign rd_err = rdreq && empty && !flush;

    assign almost_full  = (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_err || (overflow && !clear_err);
            underflow <= rd_err || (underflow && !clear_err);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr] <= data;
    end

    assign head = mem[rd_ptr];

    generate
        if (FWFT != 0) begin : g_fwft
            assign q        = empty ? '0 : head;
            assign rd_valid = !empty;
        end else begin : g_reg
            logic [WIDTH-1:0] q_r;
            logic             v_r;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    q_r <= '0;
                    v_r <= 1'b0;
                end else begin
                    v_r <= rd_en;
                    if (rd_en)
                        q_r <= head;
                end
            end

            assign q        = q_r;
            assign rd_valid = v_r;
        end
    endgenerate

endmodule

// File: tb/tb_hull_sync_fifo.sv
// Randomized and directed bench for hull_sync_fifo, comparing both read
// modes against a queue-based reference model.
module tb_hull_sync_fifo;

    localparam int W  = 8;
    localparam int LD = 2;
    localparam int D  = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          wrreq;
    logic [W-1:0]  data;
    logic          rdreq;
    logic          clear_err;
    logic [LD:0]   af_thresh;
    logic [LD:0]   ae_thresh;

    logic          full_a, empty_a, rdv_a, af_a, ae_a, ovf_a, unf_a;
    logic [W-1:0]  q_a;
    logic [LD:0]   cnt_a;
    logic          full_b, empty_b, rdv_b, af_b, ae_b, ovf_b, unf_b;
    logic [W-1:0]  q_b;
    logic [LD:0]   cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] mq[$];
    logic         ovf_m;
    logic         unf_m;
    logic [W-1:0] q0_m;
    logic         rdv0_m;

    always #5 clock = ~clock;

    hull_sync_fifo #(.WIDTH(W), .LOG_DEPTH(LD), .FWFT(1)) u_fw (
        .clock(clock), .reset(reset), .flush(flush),
        .wrreq(wrreq), .data(data), .full(full_a),
        .rdreq(rdreq), .q(q_a), .empty(empty_a), .rd_valid(rdv_a),
        .count(cnt_a), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .almost_full(af_a), .almost_empty(ae_a),
        .overflow(ovf_a), .underflow(unf_a), .clear_err(clear_err)
    );

    hull_sync_fifo #(.WIDTH(W), .LOG_DEPTH(LD), .FWFT(0)) u_rg (
        .clock(clock), .reset(reset), .flush(flush),
        .wrreq(wrreq), .data(data), .full(full_b),
        .rdreq(rdreq), .q(q_b), .empty(empty_b), .rd_valid(rdv_b),
        .count(cnt_b), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .almost_full(af_b), .almost_empty(ae_b),
        .overflow(ovf_b), .underflow(unf_b), .clear_err(clear_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        ovf_m  = 1'b0;
        unf_m  = 1'b0;
        q0_m   = '0;
        rdv0_m = 1'b0;
    endtask

    task automatic check_all();
        int n;
        logic [W-1:0] hq;
        n  = mq.size();
        hq = (n == 0) ? '0 : mq[0];
        chk("count_fw", 32'(cnt_a), 32'(n));
        chk("count_rg", 32'(cnt_b), 32'(n));
        chk("empty_fw", 32'(empty_a), 32'(n == 0));
        chk("empty_rg", 32'(empty_b), 32'(n == 0));
        chk("full_fw", 32'(full_a), 32'(n == D));
        chk("full_rg", 32'(full_b), 32'(n == D));
        chk("afull_fw", 32'(af_a), 32'(n >= int'(af_thresh)));
        chk("aempty_fw", 32'(ae_a), 32'(n <= int'(ae_thresh)));
        chk("afull_rg", 32'(af_b), 32'(n >= int'(af_thresh)));
        chk("aempty_rg", 32'(ae_b), 32'(n <= int'(ae_thresh)));
        chk("ovf_fw", 32'(ovf_a), 32'(ovf_m));
        chk("unf_fw", 32'(unf_a), 32'(unf_m));
        chk("ovf_rg", 32'(ovf_b), 32'(ovf_m));
        chk("unf_rg", 32'(unf_b), 32'(unf_m));
        chk("q_fw", 32'(q_a), 32'(hq));
        chk("rdv_fw", 32'(rdv_a), 32'(n != 0));
        chk("q_rg", 32'(q_b), 32'(q0_m));
        chk("rdv_rg", 32'(rdv_b), 32'(rdv0_m));
    endtask

    // Called at a falling edge: apply inputs, advance the model across
    // the rising edge, then compare at the next falling edge.
    task automatic drive(input logic wr, input logic [W-1:0] d,
                         input logic rd, input logic fl, input logic cl);
        bit f;
        bit e;
        wrreq     = wr;
        data      = d;
        rdreq     = rd;
        flush     = fl;
        clear_err = cl;
        @(posedge clock);
        f = (mq.size() == D);
        e = (mq.size() == 0);
        ovf_m = (wr && f && !fl) || (ovf_m && !cl);
        unf_m = (rd && e && !fl) || (unf_m && !cl);
        if (fl) begin
            mq.delete();
            rdv0_m = 1'b0;
        end else begin
            rdv0_m = rd && !e;
            if (rd && !e)
                q0_m = mq.pop_front();
            if (wr && !f)
                mq.push_back(d);
        end
        @(negedge clock);
        wrreq     = 1'b0;
        rdreq     = 1'b0;
        flush     = 1'b0;
        clear_err = 1'b0;
        check_all();
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_cnt"}, 32'(cnt_a), 0);
        chk({tag, "_empty"}, 32'(empty_a), 1);
        chk({tag, "_full"}, 32'(full_b), 0);
        chk({tag, "_q_fw"}, 32'(q_a), 0);
        chk({tag, "_q_rg"}, 32'(q_b), 0);
        chk({tag, "_rdv_rg"}, 32'(rdv_b), 0);
        chk({tag, "_ovf"}, 32'(ovf_a | ovf_b), 0);
        chk({tag, "_unf"}, 32'(unf_a | unf_b), 0);
        chk({tag, "_ae"}, 32'(ae_a), 1);
        chk({tag, "_af"}, 32'(af_a), 32'(af_thresh == 0));
    endtask

    initial begin
        logic [W-1:0] exp_d[$];
        reset     = 1'b1;
        flush     = 1'b0;
        wrreq     = 1'b0;
        rdreq     = 1'b0;
        clear_err = 1'b0;
        data      = '0;
        af_thresh = 3'd4;
        ae_thresh = 3'd0;
        model_reset();
        @(negedge clock);
        reset_check("rst0");
        reset = 1'b0;
        @(negedge clock);
        check_all();

        // Fill, overflow, drain in order
        drive(1, 8'h0A, 0, 0, 0);
        drive(1, 8'h0B, 0, 0, 0);
        drive(1, 8'h0C, 0, 0, 0);
        drive(1, 8'h0D, 0, 0, 0);
        chk("fill_full", 32'(full_a), 1);
        chk("fill_cnt", 32'(cnt_a), 4);
        drive(1, 8'hEE, 0, 0, 0);
        chk("ovf_set", 32'(ovf_a), 1);
        chk("ovf_cnt", 32'(cnt_a), 4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_q", 32'(q_a), 32'(8'h0A + i));
            drive(0, 8'h00, 1, 0, 0);
        end
        chk("drain_empty", 32'(empty_a), 1);
        drive(0, 8'h00, 0, 0, 1);
        chk("clr_ovf", 32'(ovf_a), 0);

        // Simultaneous requests at full and at empty
        for (int i = 0; i < 4; i++)
            drive(1, 8'(8'h20 + i), 0, 0, 0);
        drive(1, 8'h99, 1, 0, 0);
        chk("both_full_cnt", 32'(cnt_a), 3);
        chk("both_full_ovf", 32'(ovf_a), 1);
        drive(0, 8'h00, 0, 1, 1);
        drive(1, 8'h42, 1, 0, 0);
        chk("both_empty_cnt", 32'(cnt_a), 1);
        chk("both_empty_unf", 32'(unf_a), 1);
        drive(0, 8'h00, 1, 0, 1);

        // Set wins over clear
        drive(0, 8'h00, 1, 0, 1);
        chk("set_wins", 32'(unf_b), 1);
        drive(0, 8'h00, 0, 0, 1);

        // Registered read latency and hold
        drive(1, 8'h55, 0, 0, 0);
        drive(0, 8'h00, 1, 0, 0);
        chk("reg_rdv", 32'(rdv_b), 1);
        chk("reg_q", 32'(q_b), 32'h55);
        drive(0, 8'h00, 0, 0, 0);
        chk("reg_rdv_drop", 32'(rdv_b), 0);
        chk("reg_q_hold", 32'(q_b), 32'h55);

        // Threshold flags across fill, plus same-cycle threshold change
        af_thresh = 3'd3;
        ae_thresh = 3'd1;
        #1;
        chk("thr_ae0", 32'(ae_a), 1);
        chk("thr_af0", 32'(af_a), 0);
        for (int c = 1; c <= 4; c++) begin
            drive(1, 8'(c), 0, 0, 0);
            chk("thr_ae", 32'(ae_a), 32'(c <= 1));
            chk("thr_af", 32'(af_b), 32'(c >= 3));
        end
        af_thresh = 3'd5;
        #1;
        chk("thr_af_live", 32'(af_a), 0);
        af_thresh = 3'd3;
        drive(0, 8'h00, 0, 1, 0);

        // Ten write/read pairs wrap the pointers
        for (int i = 0; i < 10; i++) begin
            exp_d.push_back(8'(8'h70 + i));
            drive(1, 8'(8'h70 + i), 0, 0, 0);
            chk("wrap_q_fw", 32'(q_a), 32'(exp_d[0]));
            drive(0, 8'h00, 1, 0, 0);
            chk("wrap_q_rg", 32'(q_b), 32'(exp_d.pop_front()));
        end

        // Flush at count 2 ignores concurrent requests
        drive(1, 8'h31, 0, 0, 0);
        drive(1, 8'h32, 0, 0, 0);
        drive(1, 8'h33, 1, 1, 0);
        chk("flush_cnt", 32'(cnt_a), 0);
        chk("flush_empty", 32'(empty_b), 1);
        chk("flush_noflag", 32'(ovf_a | unf_a), 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                af_thresh = 3'($urandom_range(0, 5));
                ae_thresh = 3'($urandom_range(0, 5));
            end
            drive(1'($urandom_range(0, 99) < 55), 8'($urandom),
                  1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset mid-stream
        drive(1, 8'hA1, 0, 0, 0);
        drive(1, 8'hA2, 1, 0, 0);
        drive(1, 8'hA3, 1, 0, 0);
        drive(1, 8'hA4, 0, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        reset_check("rst_mid");
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        check_all();
        drive(1, 8'h5A, 0, 0, 0);
        chk("post_rst_q", 32'(q_a), 32'h5A);
        chk("post_rst_cnt", 32'(cnt_b), 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hull_sync_fifo.md
HULL_SYNC_FIFO -- requirements
Module: hull_sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (>=1).
REQ-002 SHALL have parameter LOG_DEPTH, default 4, giving DEPTH = 2^LOG_DEPTH entries (1..12).
REQ-003 SHALL have parameter FWFT, default 1; 1 = first-word-fall-through read, 0 = registered read with 1-cycle latency.
REQ-004 SHALL have port clock, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port flush, input, 1, synchronous clear of contents.
REQ-007 SHALL have port wrreq, input, 1, enqueue request.
REQ-008 SHALL have port data, input, WIDTH, enqueue data.
REQ-009 SHALL have port full, output, 1, count == DEPTH.
REQ-010 SHALL have port rdreq, input, 1, dequeue request.
REQ-011 SHALL have port q, output, WIDTH, dequeue data.
REQ-012 SHALL have port empty, output, 1, count == 0.
REQ-013 SHALL have port rd_valid, output, 1, q valid (FWFT=0 only; equals !empty when FWFT=1).
REQ-014 SHALL have port count, output, LOG_DEPTH+1, current occupancy.
REQ-015 SHALL have port af_thresh, input, LOG_DEPTH+1, almost-full threshold.
REQ-016 SHALL have port ae_thresh, input, LOG_DEPTH+1, almost-empty threshold.
REQ-017 SHALL have port almost_full, output, 1, count >= af_thresh.
REQ-018 SHALL have port almost_empty, output, 1, count <= ae_thresh.
REQ-019 SHALL have port overflow, output, 1, sticky: write attempted while full.
REQ-020 SHALL have port underflow, output, 1, sticky: read attempted while empty.
REQ-021 SHALL have port clear_err, input, 1, clears overflow/underflow.

Function
REQ-022 Write accepted iff wrreq && !full; read accepted iff rdreq && !empty; no bypass (write into empty FIFO not readable same cycle; read from full FIFO does not free a slot for a same-cycle write).
REQ-023 count SHALL be a register: +1 on write only, -1 on read only, unchanged on both or neither; full/empty/almost_* derive from registered count.
REQ-024 Write/read pointers LOG_DEPTH bits, increment modulo DEPTH on accepted op, wrap DEPTH-1 -> 0.
REQ-025 FWFT=1: q = entry at read pointer when !empty, 0 when empty; data written to empty FIFO appears on q the next cycle.
REQ-026 FWFT=0: q registered, loaded with head entry on accepted read, rd_valid=1 exactly the cycle after each accepted read; q holds value otherwise.
REQ-027 overflow sets on wrreq && full; underflow sets on rdreq && empty; set and clear_err in same cycle -> set wins.
REQ-028 flush: next cycle pointers=0, count=0, rd_valid=0; concurrent wrreq/rdreq ignored and not flagged; stored data and sticky flags unchanged.
REQ-029 Threshold inputs are compared combinationally against count; changes take effect same cycle.

Reset
REQ-030 On reset assertion, immediately: count=0, pointers=0, empty=1, full=0, rd_valid=0, q=0, overflow=0, underflow=0; almost_empty=1; almost_full=(af_thresh==0).
REQ-031 Reset mid-operation discards all contents; first write after deassertion behaves as write to empty FIFO.

Verification
REQ-032 LOG_DEPTH=2, FWFT=1: write 0xA,0xB,0xC,0xD -> full=1, count=4; 5th wrreq -> rejected, overflow=1; 4 reads -> q sequence A,B,C,D, empty=1.
REQ-033 Full FIFO, wrreq=rdreq=1 one cycle -> read accepted, write rejected, count=3, overflow=1; empty FIFO same stimulus -> count=1, underflow=1.
REQ-034 FWFT=0: write 0x55, rdreq next cycle -> rd_valid=1 and q=0x55 one cycle later, q holds after.
REQ-035 af_thresh=3, ae_thresh=1: fill 0->4 -> almost_empty high at count 0,1; almost_full high at count 3,4.
REQ-036 10 write/read pairs through depth-4 FIFO -> pointers wrap, data in order; flush at count=2 -> count=0, empty=1 next cycle; reset asserted mid-stream -> outputs per REQ-030 without clock edge.
